// File: rtl/layer_pkg.sv
// layer_pkg: shared width derivations, log helper and FSM encoding for the layer sequencer
package layer_pkg;
  function automatic int clog(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic int max1(input int v);
    return v < 1 ? 1 : v;
  endfunction
  function automatic int res_w(input int n);
    return 16 + clog(n);
  endfunction
  function automatic int ia_w(input int n);
    return max1(clog(n));
  endfunction
  function automatic int wa_w(input int n, input int m);
    return max1(clog(n * m));
  endfunction
  function automatic int oa_w(input int m);
    return max1(clog(m));
  endfunction
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_READ, S_DRAIN, S_STORE, S_DONE} state_e;
endpackage

// File: rtl/layer_sequencer_nested_counter.sv
// nested_counter: inner pair index k, outer neuron index j and flat weight address j*N+k
module nested_counter import layer_pkg::*; #(
  parameter int N = 2,
  parameter int M = 4,
  localparam int IA_W = ia_w(N),
  localparam int WA_W = wa_w(N, M),
  localparam int OA_W = oa_w(M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            outer_clr_i,
  input  logic            inner_clr_i,
  input  logic            inner_inc_i,
  input  logic            outer_inc_i,
  output logic [IA_W-1:0] inner_o,
  output logic [OA_W-1:0] outer_o,
  output logic [WA_W-1:0] addr_o,
  output logic            inner_last_o,
  output logic            outer_last_o
);
  logic [IA_W-1:0] k_q, k_d;
  logic [OA_W-1:0] j_q, j_d;
  logic [WA_W-1:0] a_q, a_d;
  // counter registers
  always_ff @(posedge clk)
    if (rst) begin
      k_q <= '0;
      j_q <= '0;
      a_q <= '0;
    end else begin
      k_q <= k_d;
      j_q <= j_d;
      a_q <= a_d;
    end
  // the flat address simply keeps counting across rows, so it lands on (j+1)*N without a multiply
  always_comb begin
    inner_last_o = k_q == IA_W'(N - 1);
    outer_last_o = j_q == OA_W'(M - 1);
    k_d = (inner_clr_i || (inner_inc_i && inner_last_o)) ? '0 : inner_inc_i ? k_q + 1'b1 : k_q;
    j_d = outer_clr_i ? '0 : outer_inc_i ? j_q + 1'b1 : j_q;
    a_d = outer_clr_i ? '0 : inner_inc_i ? a_q + 1'b1 : a_q;
  end
  assign inner_o = k_q;
  assign outer_o = j_q;
  assign addr_o = a_q;
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: time-multiplexes one MAC engine over all neurons of a fully connected layer
module layer_sequencer import layer_pkg::*; #(
  parameter int N = 2,
  parameter int M = 4,
  localparam int RES_W = res_w(N),
  localparam int IA_W = ia_w(N),
  localparam int WA_W = wa_w(N, M),
  localparam int OA_W = oa_w(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             relu_en,
  output logic             busy,
  output logic             done,
  output logic             in_rd_en,
  output logic             w_rd_en,
  output logic [IA_W-1:0]  in_addr,
  output logic [WA_W-1:0]  w_addr,
  input  logic [7:0]       in_rdata,
  input  logic [7:0]       w_rdata,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [7:0]       mac_x,
  output logic [7:0]       mac_w,
  input  logic [RES_W-1:0] mac_res,
  output logic             out_we,
  output logic [OA_W-1:0]  out_addr,
  output logic [RES_W-1:0] out_wdata
);
  state_e state_q, state_d;
  logic relu_q, relu_d, vld_q, accept, inner_last, outer_last;
  nested_counter #(.N(N), .M(M)) u_cnt (
    .clk(clk),
    .rst(rst),
    .outer_clr_i(accept),
    .inner_clr_i(mac_clr),
    .inner_inc_i(in_rd_en),
    .outer_inc_i(out_we && !outer_last),
    .inner_o(in_addr),
    .outer_o(out_addr),
    .addr_o(w_addr),
    .inner_last_o(inner_last),
    .outer_last_o(outer_last)
  );
  // state, latched relu mode and the read-valid pipe that becomes mac_en
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      relu_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      relu_q <= relu_d;
      vld_q <= in_rd_en;
    end
  // next state; relu mode is captured only when a run is accepted
  always_comb begin
    state_d = state_q;
    relu_d = relu_q;
    case (state_q)
      S_IDLE: begin
        state_d = start ? S_CLR : S_IDLE;
        relu_d = start ? relu_en : relu_q;
      end
      S_CLR: state_d = S_READ;
      S_READ: state_d = inner_last ? S_DRAIN : S_READ;
      S_DRAIN: state_d = S_STORE;
      S_STORE: state_d = outer_last ? S_DONE : S_CLR;
      default: state_d = S_IDLE;
    endcase
  end
  // state-decoded outputs; operands and write data are forced to zero when not qualified
  always_comb begin
    accept = state_q == S_IDLE && start;
    busy = state_q != S_IDLE || start;
    done = state_q == S_DONE;
    in_rd_en = state_q == S_READ;
    w_rd_en = state_q == S_READ;
    mac_clr = state_q == S_CLR;
    mac_en = vld_q;
    mac_x = vld_q ? in_rdata : 8'd0;
    mac_w = vld_q ? w_rdata : 8'd0;
    out_we = state_q == S_STORE;
    out_wdata = (out_we && !(relu_q && mac_res[RES_W-1])) ? mac_res : '0;
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench for an N=2/M=2 and an N=1/M=1 sequencer
module tb_layer_sequencer;
  typedef struct {int a; int d;} wr_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, start0 = 1'b0, relu0 = 1'b0, start1 = 1'b0, relu1 = 1'b0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic busy0, done0, ird0, wrd0, clr0, men0, we0;
  logic [0:0] ia0, oa0;
  logic [1:0] wa0;
  logic [7:0] rx0 = 8'd0, rw0 = 8'd0, mx0, mw0;
  logic [16:0] wd0;
  logic signed [16:0] acc0;
  logic signed [7:0] x0 [2];
  logic signed [7:0] w0 [4];
  layer_sequencer #(.N(2), .M(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .relu_en(relu0), .busy(busy0), .done(done0),
    .in_rd_en(ird0), .w_rd_en(wrd0), .in_addr(ia0), .w_addr(wa0), .in_rdata(rx0), .w_rdata(rw0),
    .mac_clr(clr0), .mac_en(men0), .mac_x(mx0), .mac_w(mw0), .mac_res(acc0),
    .out_we(we0), .out_addr(oa0), .out_wdata(wd0)
  );

  logic busy1, done1, ird1, wrd1, clr1, men1, we1;
  logic [0:0] ia1, oa1, wa1;
  logic [7:0] rx1 = 8'd0, rw1 = 8'd0, mx1, mw1;
  logic [15:0] wd1;
  logic signed [15:0] acc1;
  logic signed [7:0] x1 [2];
  logic signed [7:0] w1 [2];
  layer_sequencer #(.N(1), .M(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .relu_en(relu1), .busy(busy1), .done(done1),
    .in_rd_en(ird1), .w_rd_en(wrd1), .in_addr(ia1), .w_addr(wa1), .in_rdata(rx1), .w_rdata(rw1),
    .mac_clr(clr1), .mac_en(men1), .mac_x(mx1), .mac_w(mw1), .mac_res(acc1),
    .out_we(we1), .out_addr(oa1), .out_wdata(wd1)
  );

  always @(posedge clk) begin
    if (ird0) rx0 <= x0[ia0];
    if (wrd0) rw0 <= w0[wa0];
    if (ird1) rx1 <= x1[ia1];
    if (wrd1) rw1 <= w1[wa1];
    acc0 <= (rst || clr0) ? 17'sd0 : men0 ? acc0 + $signed(mx0) * $signed(mw0) : acc0;
    acc1 <= (rst || clr1) ? 16'sd0 : men1 ? acc1 + $signed(mx1) * $signed(mw1) : acc1;
  end

  task automatic chk(input string nm, input bit ok, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int nz0();
    return $countones({busy0, done0, ird0, wrd0, ia0, wa0, clr0, men0, mx0, mw0, we0, oa0, wd0});
  endfunction
  function automatic int nz1();
    return $countones({busy1, done1, ird1, wrd1, ia1, wa1, clr1, men1, mx1, mw1, we1, oa1, wd1});
  endfunction

  wr_t q0[$], q1[$], e0, e1;
  int dq0[$], dq1[$];
  int bc0 = 0, bc1 = 0, dc0 = 0, dc1 = 0, ed0, ed1;
  logic prd0 = 1'b0, prd1 = 1'b0, prst = 1'b1;

  always @(negedge clk) if (cyc >= 1) begin
    chk("mac_en_pipe0", men0 == (prd0 && !prst), int'(men0), int'(prd0 && !prst));
    chk("mac_en_pipe1", men1 == (prd1 && !prst), int'(men1), int'(prd1 && !prst));
    chk("clr_en_overlap0", !(clr0 && men0), int'(clr0 && men0), 0);
    chk("clr_en_overlap1", !(clr1 && men1), int'(clr1 && men1), 0);
    chk("rd_en_pair0", ird0 == wrd0, int'(wrd0), int'(ird0));
    if (we0) begin
      if (q0.size() == 0) chk("unexpected_write0", 1'b0, int'(oa0), -1);
      else begin
        e0 = q0.pop_front();
        chk("wr_addr0", oa0 == e0.a, int'(oa0), e0.a);
        chk("wr_data0", int'($signed(wd0)) == e0.d, int'($signed(wd0)), e0.d);
      end
    end
    if (we1) begin
      if (q1.size() == 0) chk("unexpected_write1", 1'b0, int'(oa1), -1);
      else begin
        e1 = q1.pop_front();
        chk("wr_addr1", oa1 == e1.a, int'(oa1), e1.a);
        chk("wr_data1", int'($signed(wd1)) == e1.d, int'($signed(wd1)), e1.d);
      end
    end
    bc0 = rst ? 0 : bc0 + int'(busy0);
    bc1 = rst ? 0 : bc1 + int'(busy1);
    if (done0) begin
      ed0 = dq0.size() == 0 ? -1 : dq0.pop_front();
      chk("done_cycle0", cyc == ed0, cyc, ed0);
      chk("busy_cycles0", bc0 == 12, bc0, 12);
      bc0 = 0;
      dc0++;
    end
    if (done1) begin
      ed1 = dq1.size() == 0 ? -1 : dq1.pop_front();
      chk("done_cycle1", cyc == ed1, cyc, ed1);
      chk("busy_cycles1", bc1 == 6, bc1, 6);
      bc1 = 0;
      dc1++;
    end
    prd0 = ird0;
    prd1 = ird1;
    prst = rst;
  end

  task automatic go0(input bit r, input int v0, input int v1);
    start0 = 1'b1;
    relu0 = r;
    q0.push_back(wr_t'{0, v0});
    q0.push_back(wr_t'{1, v1});
    dq0.push_back(cyc + 11);
    @(posedge clk);
    #1 start0 = 1'b0;
    relu0 = !r;
  endtask

  task automatic wait_done0(input int n);
    int t = 0;
    while (dc0 < n && t < 200) begin
      @(posedge clk);
      #1 t++;
    end
    chk("done_timeout0", dc0 >= n, dc0, n);
  endtask

  task automatic load0(input int a, input int b, input int c, input int d, input int e, input int f);
    x0[0] = 8'(a); x0[1] = 8'(b);
    w0[0] = 8'(c); w0[1] = 8'(d); w0[2] = 8'(e); w0[3] = 8'(f);
  endtask

  initial begin
    int t;
    load0(3, 5, 1, 2, -4, 1);
    x1[0] = -8'sd128; x1[1] = 8'sd0;
    w1[0] = -8'sd128; w1[1] = 8'sd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_zero0", nz0() == 0, nz0(), 0);
    chk("reset_zero1", nz1() == 0, nz1(), 0);
    go0(1'b0, 13, -7);
    wait_done0(1);
    go0(1'b1, 13, 0);
    wait_done0(2);
    load0(-2, 7, -3, -1, 10, -6);
    go0(1'b0, -1, -62);
    wait_done0(3);
    go0(1'b1, 0, 0);
    wait_done0(4);
    start1 = 1'b1;
    relu1 = 1'b1;
    q1.push_back(wr_t'{0, 16384});
    dq1.push_back(cyc + 5);
    @(posedge clk);
    #1 start1 = 1'b0;
    t = 0;
    while (dc1 < 1 && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    chk("done_timeout1", dc1 >= 1, dc1, 1);
    load0(3, 5, 1, 2, -4, 1);
    start0 = 1'b1;
    relu0 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      q0.push_back(wr_t'{0, 13});
      q0.push_back(wr_t'{1, -7});
      dq0.push_back(cyc + 11 + 12 * r);
    end
    repeat (13) @(posedge clk);
    #1 start0 = 1'b0;
    wait_done0(6);
    start0 = 1'b1;
    q0.push_back(wr_t'{0, 13});
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("in_read_before_rst", ird0 == 1'b1, int'(ird0), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_zero0", nz0() == 0, nz0(), 0);
    repeat (8) @(posedge clk);
    #1 chk("no_done_after_rst", dc0 == 6, dc0, 6);
    go0(1'b0, 13, -7);
    wait_done0(7);
    repeat (3) @(posedge clk);
    #1 chk("sb_empty0", q0.size() == 0 && dq0.size() == 0, q0.size() + dq0.size(), 0);
    chk("sb_empty1", q1.size() == 0 && dq1.size() == 0, q1.size() + dq1.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Sequences one shared multiply-accumulate neuron engine across all M neurons of a fully connected layer. On `start` it reads the N-element input vector and the M×N weight matrix from external synchronous-read memories, feeds one operand pair per cycle to the MAC engine, and writes each neuron's result into an output buffer. An optional ReLU is applied on store. It sits between the layer-level control and the neuron datapath, and replaces per-neuron controllers when several neurons share one engine.

## Interface
Parameters:
- `N`, 2, inputs per neuron (≥1)
- `M`, 4, neurons in the layer (≥1)
- `RES_W`, 16+clog(N), MAC result width (derived, localparam)
- `IA_W` / `WA_W` / `OA_W`, max(1,clog(N)) / max(1,clog(N*M)) / max(1,clog(M)), address widths (derived)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  start request, sampled in IDLE only
- `relu_en`  in  1  apply ReLU on store; latched when `start` is accepted
- `busy`  out  1  high from accept until the DONE cycle, inclusive
- `done`  out  1  one-cycle pulse after the last result is stored
- `in_rd_en`, `w_rd_en`  out  1  memory read enables (1-cycle read latency)
- `in_addr`  out  IA_W  input-vector address k
- `w_addr`  out  WA_W  weight address j*N+k
- `in_rdata`, `w_rdata`  in  8  memory read data
- `mac_clr`  out  1  clear the engine accumulator
- `mac_en`  out  1  accumulate `mac_x`×`mac_w` this cycle
- `mac_x`, `mac_w`  out  8  operand pair (pass-through of read data, qualified by `mac_en`)
- `mac_res`  in  RES_W  signed accumulated result; valid the cycle after the last `mac_en`
- `out_we`  out  1  output buffer write strobe
- `out_addr`  out  OA_W  neuron index j
- `out_wdata`  out  RES_W  stored result

## Operation
- FSM states: IDLE, CLR, READ, DRAIN, STORE, DONE.
- IDLE: waits for `start`; on `start`, latches `relu_en`, sets j=0, and goes to CLR.
- CLR: asserts `mac_clr`, sets k=0, goes to READ.
- READ: asserts both rd_en signals with the current addresses; increments k; after the read with k=N-1, goes to DRAIN.
- A one-bit valid pipe delays rd_en by one cycle to produce `mac_en`, aligned with the returned data.
- DRAIN: one cycle; the last `mac_en` fires here.
- STORE: `out_we`=1, `out_addr`=j. `out_wdata` = 0 if latched relu and `mac_res` is negative, otherwise `mac_res`. Then j==M-1 → DONE; else j++ and go to CLR.
- DONE: `done`=1, `busy`=1, then IDLE.
- `start` is ignored outside IDLE. It is also ignored in the DONE cycle; `start` arriving in IDLE the next cycle is accepted.
- `rst` at any point: returns to IDLE; j, k, and the valid pipe clear to 0; no further `mac_en` or `out_we` is issued.
- Reset values: all outputs 0, including addresses and data.
- N=1: READ lasts one cycle. M=1: the first STORE goes directly to DONE.

## Timing
- Accept at cycle 0 (IDLE with `start`=1).
- Per neuron: N+3 cycles (CLR + N×READ + DRAIN + STORE).
- `done` is high in cycle 1+M·(N+3).
  - Example: N=2, M=1 → cycle 6.
  - Example: N=2, M=2 → cycle 11.
- `mac_en` for pair k of neuron j is high exactly one cycle after the corresponding read.
- `mac_clr` and `mac_en` are never asserted in the same cycle.
- `out_we` occurs exactly once per neuron, in ascending j order.

## Structure
- Shared package `layer_pkg`:
  - `clog` function
  - FSM state encoding constants
  - `RES_W` / address width derivations, so the neuron datapath and the output buffer agree
- Sub-module `nested_counter`:
  - inner k (0..N-1) and outer j (0..M-1)
  - outputs: `inner_last`, `outer_last`, and the linear weight address j*N+k, maintained incrementally without a multiplier
- The FSM, valid pipe and ReLU mux live in `layer_sequencer`.

## Test plan
- N=2, M=2, x={3,5}, W={1,2; −4,1}, relu_en=0 → writes j0=13, j1=−7 (17-bit 0x1FFF9); `done` at cycle 11; `busy` high cycles 0–11.
- Same data, relu_en=1 → writes 13, 0; flipping `relu_en` after accept has no effect.
- `start` held high continuously → a second run begins the cycle after DONE/IDLE; `start` pulses mid-run are ignored (exactly 2 writes per run).
- `rst` asserted during READ of neuron 1 → the next cycle has all outputs 0 and state IDLE; no `out_we` for j=1; a fresh `start` completes a normal run.
- N=1, M=1, x={−128}, w={−128}, relu_en=1 → writes 16384; `done` at cycle 5.
- Protocol checker throughout: `mac_en` equals rd_en delayed by one cycle; no overlap of `mac_clr` and `mac_en`; `out_addr` increments 0..M-1.
